// File: rtl/cla_add_arbiter.sv
// Round-robin arbiter sharing one 64-bit carry-lookahead adder between two requesters.
// Multi-beat add/sub transactions lock the grant and chain the carry between beats.
module cla_add_arbiter #(
  parameter int   W       = 64,
  parameter logic RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  input  logic         r0_cin,
  input  logic         r0_sub,
  input  logic         r0_last,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  input  logic         r1_cin,
  input  logic         r1_sub,
  input  logic         r1_last,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_s,
  output logic         res_cout,
  output logic         res_id,
  output logic         res_last
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_rr;
  logic           r_carry;
  logic           r_sub;
  logic           r_res_valid;
  logic [W-1:0]   r_res_s;
  logic           r_res_cout;
  logic           r_res_id;
  logic           r_res_last;

  logic           w_gnt_valid;
  logic           w_gnt_id;
  logic           w_free;
  logic           w_first;
  logic           w_accept;
  logic           w_own0;
  logic           w_own1;
  logic           w_sel_sub;
  logic           w_sel_cin;
  logic           w_sel_last;
  logic           w_eff_sub;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic [W-1:0]   w_add_a;
  logic [W-1:0]   w_add_b;
  logic           w_add_cin;
  logic [W-1:0]   w_sum;
  logic           w_cout;
  logic [W-1:0]   w_g;
  logic [W-1:0]   w_p;
  logic [W-1:0]   w_c;
  logic [W/4-1:0] w_gg;
  logic [W/4-1:0] w_gp;
  logic [W/4:0]   w_gc;

  // Grant selection: IDLE arbitrates round-robin, BUSY stays locked to the owner.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r0_valid && r1_valid) begin
          w_gnt_valid = 1'b1;
          w_gnt_id    = r_rr;
        end else if (r0_valid) begin
          w_gnt_valid = 1'b1;
          w_gnt_id    = 1'b0;
        end else if (r1_valid) begin
          w_gnt_valid = 1'b1;
          w_gnt_id    = 1'b1;
        end else begin
          w_gnt_valid = 1'b0;
          w_gnt_id    = 1'b0;
        end
      end
      ST_BUSY0: begin
        w_gnt_valid = r0_valid;
        w_gnt_id    = 1'b0;
      end
      ST_BUSY1: begin
        w_gnt_valid = r1_valid;
        w_gnt_id    = 1'b1;
      end
      default: begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = 1'b0;
      end
    endcase
  end

  assign w_free   = !r_res_valid || res_ready;
  assign w_first  = (r_state == ST_IDLE);
  assign w_own0   = (r_state == ST_BUSY0) || (w_first && w_gnt_valid && !w_gnt_id);
  assign w_own1   = (r_state == ST_BUSY1) || (w_first && w_gnt_valid && w_gnt_id);
  assign r0_ready = rst_n && w_free && w_own0;
  assign r1_ready = rst_n && w_free && w_own1;
  assign w_accept = rst_n && w_free && w_gnt_valid;

  assign w_sel_a    = w_gnt_id ? r1_a    : r0_a;
  assign w_sel_b    = w_gnt_id ? r1_b    : r0_b;
  assign w_sel_cin  = w_gnt_id ? r1_cin  : r0_cin;
  assign w_sel_sub  = w_gnt_id ? r1_sub  : r0_sub;
  assign w_sel_last = w_gnt_id ? r1_last : r0_last;

  // Subtraction is A + ~B + 1; the sub flag only counts on the first beat.
  assign w_eff_sub = w_first ? w_sel_sub : r_sub;
  assign w_add_a   = w_sel_a;
  assign w_add_b   = w_eff_sub ? ~w_sel_b : w_sel_b;
  assign w_add_cin = w_first ? (w_sel_sub ? 1'b1 : w_sel_cin) : r_carry;

  // 64-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
  always_comb begin
    w_g     = w_add_a & w_add_b;
    w_p     = w_add_a ^ w_add_b;
    w_gg    = '0;
    w_gp    = '0;
    w_gc    = '0;
    w_c     = '0;
    w_gc[0] = w_add_cin;
    for (int k = 0; k < W/4; k++) begin
      w_gp[k]     = &w_p[4*k +: 4];
      w_gg[k]     = w_g[4*k+3]
                  | (w_p[4*k+3] & w_g[4*k+2])
                  | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                  | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gc[k+1]   = w_gg[k] | (w_gp[k] & w_gc[k]);
      w_c[4*k]    = w_gc[k];
      w_c[4*k+1]  = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2]  = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                  | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3]  = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                  | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                  | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
    w_sum  = w_p ^ w_c;
    w_cout = w_gc[W/4];
  end

  // Lock state, chained carry and the registered result beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr        <= RR_INIT;
      r_carry     <= 1'b0;
      r_sub       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_s     <= '0;
      r_res_cout  <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_last  <= 1'b0;
    end else if (w_accept) begin
      r_carry     <= w_cout;
      r_sub       <= w_eff_sub;
      r_res_valid <= 1'b1;
      r_res_s     <= w_sum;
      r_res_cout  <= w_cout;
      r_res_id    <= w_gnt_id;
      r_res_last  <= w_sel_last;
      if (w_sel_last) begin
        r_state <= ST_IDLE;
        r_rr    <= ~w_gnt_id;
      end else begin
        r_state <= w_gnt_id ? ST_BUSY1 : ST_BUSY0;
      end
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_s     = r_res_s;
  assign res_cout  = r_res_cout;
  assign res_id    = r_res_id;
  assign res_last  = r_res_last;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed self-checking bench for cla_add_arbiter: adds, subs, chaining, arbitration,
// backpressure and mid-transaction reset, with hand-computed expectations.
module tb_cla_add_arbiter;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_cin, r0_sub, r0_last;
  logic [63:0] r0_a, r0_b;
  logic        r1_valid, r1_ready, r1_cin, r1_sub, r1_last;
  logic [63:0] r1_a, r1_b;
  logic        res_valid, res_ready, res_cout, res_id, res_last;
  logic [63:0] res_s;

  int checks = 0;
  int errors = 0;

  cla_add_arbiter #(.W(64), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_cin(r0_cin), .r0_sub(r0_sub), .r0_last(r0_last),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_cin(r1_cin), .r1_sub(r1_sub), .r1_last(r1_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s),
    .res_cout(res_cout), .res_id(res_id), .res_last(res_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic id, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub, input logic last);
    if (id) begin
      r1_valid = 1'b1; r1_a = a; r1_b = b; r1_cin = cin; r1_sub = sub; r1_last = last;
    end else begin
      r0_valid = 1'b1; r0_a = a; r0_b = b; r0_cin = cin; r0_sub = sub; r0_last = last;
    end
  endtask

  // One beat from requester id, accepted at the next edge; result checked just after it.
  task automatic beat(input string tag, input logic id, input logic [63:0] a, input logic [63:0] b,
                      input logic cin, input logic sub, input logic last,
                      input logic [63:0] es, input logic ec);
    drive(id, a, b, cin, sub, last);
    #1;
    chk({tag, "_rdy"}, id ? {63'd0, r1_ready} : {63'd0, r0_ready}, 64'd1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    chk({tag, "_vld"},  {63'd0, res_valid}, 64'd1);
    chk({tag, "_s"},    res_s, es);
    chk({tag, "_cout"}, {63'd0, res_cout}, {63'd0, ec});
    chk({tag, "_id"},   {63'd0, res_id}, {63'd0, id});
    chk({tag, "_last"}, {63'd0, res_last}, {63'd0, last});
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; res_ready = 1'b1;
    r0_valid = 1'b1; r0_a = '0; r0_b = '0; r0_cin = 1'b0; r0_sub = 1'b0; r0_last = 1'b0;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_cin = 1'b0; r1_sub = 1'b0; r1_last = 1'b0;
    #12;
    chk("rst_vld",  {63'd0, res_valid}, 64'd0);
    chk("rst_s",    res_s, 64'd0);
    chk("rst_cout", {63'd0, res_cout}, 64'd0);
    chk("rst_id",   {63'd0, res_id}, 64'd0);
    chk("rst_last", {63'd0, res_last}, 64'd0);
    chk("rst_rdy0", {63'd0, r0_ready}, 64'd0);
    r0_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    beat("t1",  1'b0, 64'd5, 64'd12, 1'b0, 1'b0, 1'b1, 64'd17, 1'b0);
    beat("t2",  1'b0, ONES, ONES, 1'b1, 1'b0, 1'b1, ONES, 1'b1);
    beat("t3a", 1'b1, ONES, 64'd1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    beat("t3b", 1'b1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd1, 1'b0);
    beat("t4a", 1'b0, 64'd5, 64'd12, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    beat("t4b", 1'b1, 64'd12, 64'd5, 1'b0, 1'b1, 1'b1, 64'd7, 1'b1);

    // Fresh reset so the round-robin pointer starts at requester 0.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'd10, 64'd20, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t5_rdy0a", {63'd0, r0_ready}, 64'd1);
    chk("t5_rdy1a", {63'd0, r1_ready}, 64'd0);
    @(posedge clk); #1;
    chk("t5_s0", res_s, 64'd3);
    chk("t5_id0", {63'd0, res_id}, 64'd0);
    drive(1'b0, 64'd3, 64'd4, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t5_rdy0b", {63'd0, r0_ready}, 64'd1);
    chk("t5_rdy1b", {63'd0, r1_ready}, 64'd0);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    chk("t5_s1", res_s, 64'd7);
    chk("t5_last1", {63'd0, res_last}, 64'd1);
    beat("t5c", 1'b1, 64'd10, 64'd20, 1'b0, 1'b0, 1'b0, 64'd30, 1'b0);
    beat("t5d", 1'b1, 64'd100, 64'd200, 1'b0, 1'b0, 1'b1, 64'd300, 1'b0);
    drive(1'b0, 64'd7, 64'd8, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'd9, 64'd9, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t5_rdy0c", {63'd0, r0_ready}, 64'd1);
    chk("t5_rdy1c", {63'd0, r1_ready}, 64'd0);
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("t5_s2", res_s, 64'd15);
    chk("t5_id2", {63'd0, res_id}, 64'd0);
    beat("t5e", 1'b1, 64'd9, 64'd9, 1'b0, 1'b0, 1'b1, 64'd18, 1'b0);

    // Backpressure in the middle of a 3-beat chained add.
    beat("t6a", 1'b0, ONES, ONES, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    res_ready = 1'b0;
    drive(1'b0, ONES, 64'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_bp_rdy", {63'd0, r0_ready}, 64'd0);
      @(posedge clk); #1;
      chk("t6_bp_vld",  {63'd0, res_valid}, 64'd1);
      chk("t6_bp_s",    res_s, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("t6_bp_cout", {63'd0, res_cout}, 64'd1);
    end
    res_ready = 1'b1;
    beat("t6b", 1'b0, ONES, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    beat("t6c", 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd1, 1'b0);

    // Reset after the first beat of a carry-producing transaction.
    beat("t7a", 1'b1, ONES, 64'd1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_vld",  {63'd0, res_valid}, 64'd0);
    chk("t7_rst_cout", {63'd0, res_cout}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    beat("t7b", 1'b1, 64'd5, 64'd6, 1'b0, 1'b0, 1'b1, 64'd11, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
